// File: rtl/timer_pkg.sv
// timer_pkg: state encoding, default keypad codes and BCD terminal digits
// shared by the timer sequencer and its key strobe.
package timer_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        PAUSE = 3'd4,
        DONE  = 3'd5
    } state_t;
    localparam logic [3:0] DEF_KEY_START = 4'hA;
    localparam logic [3:0] DEF_KEY_STOP  = 4'hB;
    localparam logic [3:0] DEF_KEY_CLEAR = 4'hC;
    localparam logic [3:0] DEF_KEY_DIR   = 4'hD;
    localparam logic [3:0] BCD_ZERO      = 4'h0;
    localparam logic [3:0] BCD_NINE      = 4'h9;
endpackage

// File: rtl/key_strobe.sv
// key_strobe: turns a held keypad level into a single-cycle event carrying the
// key code; the event is combinational so the FSM reacts on the sampling edge.
module key_strobe (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       key_valid,
    output logic       key_evt,
    output logic [3:0] key_code
);
    logic       kv_q;
    logic [3:0] key_q;
    assign key_evt  = key_valid & ~kv_q;
    assign key_code = key_evt ? key : key_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            kv_q  <= 1'b0;
            key_q <= '0;
        end else begin
            kv_q <= key_valid;
            if (key_evt) key_q <= key;
        end
    end
endmodule

// File: rtl/timer_sequencer.sv
// timer_sequencer: keypad-driven control FSM for the 4-digit BCD counter;
// gathers the preset, loads/starts/pauses the counter and raises the alarm.
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int         ALARM_CYCLES = 16,
    parameter logic [3:0] KEY_START    = DEF_KEY_START,
    parameter logic [3:0] KEY_STOP     = DEF_KEY_STOP,
    parameter logic [3:0] KEY_CLEAR    = DEF_KEY_CLEAR,
    parameter logic [3:0] KEY_DIR      = DEF_KEY_DIR
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic       cnt_zero,
    input  logic       cnt_max,
    output logic [3:0] pre_m,
    output logic [3:0] pre_c,
    output logic [3:0] pre_d,
    output logic [3:0] pre_u,
    output logic       load,
    output logic       run,
    output logic       func,
    output logic       entry,
    output logic       alarm,
    output logic [2:0] state
);
    localparam int AW = ALARM_CYCLES > 1 ? $clog2(ALARM_CYCLES) : 1;
    state_t        st;
    logic [AW-1:0] atmr;
    logic          key_evt;
    logic [3:0]    key_code;
    logic          pre_zero, pre_full, pre_term, cnt_term;
    logic          k_start, k_stop, k_clear, k_dir, k_digit;
    key_strobe u_strobe (
        .clock    (clock),
        .reset    (reset),
        .key      (key),
        .key_valid(key_valid),
        .key_evt  (key_evt),
        .key_code (key_code)
    );
    assign state    = st;
    assign pre_zero = pre_m == BCD_ZERO && pre_c == BCD_ZERO && pre_d == BCD_ZERO && pre_u == BCD_ZERO;
    assign pre_full = pre_m == BCD_NINE && pre_c == BCD_NINE && pre_d == BCD_NINE && pre_u == BCD_NINE;
    assign pre_term = func ? pre_zero : pre_full;
    assign cnt_term = func ? cnt_zero : cnt_max;
    assign k_start  = key_evt && key_code == KEY_START;
    assign k_stop   = key_evt && key_code == KEY_STOP;
    assign k_clear  = key_evt && key_code == KEY_CLEAR;
    assign k_dir    = key_evt && key_code == KEY_DIR;
    assign k_digit  = key_evt && key_code <= BCD_NINE;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st    <= IDLE;
            pre_m <= '0;
            pre_c <= '0;
            pre_d <= '0;
            pre_u <= '0;
            load  <= 1'b0;
            run   <= 1'b0;
            func  <= 1'b0;
            entry <= 1'b1;
            alarm <= 1'b0;
            atmr  <= '0;
        end else begin
            load <= 1'b0;
            if (k_clear) begin
                st    <= IDLE;
                pre_m <= '0;
                pre_c <= '0;
                pre_d <= '0;
                pre_u <= '0;
                load  <= 1'b1;
                run   <= 1'b0;
                alarm <= 1'b0;
                entry <= 1'b1;
            end else begin
                case (st)
                    IDLE, ENTRY: begin
                        if (k_digit) begin
                            pre_m <= pre_c;
                            pre_c <= pre_d;
                            pre_d <= pre_u;
                            pre_u <= key_code;
                            st    <= ENTRY;
                        end else if (k_dir) begin
                            func <= ~func;
                        end else if (k_start) begin
                            st    <= LOAD;
                            load  <= 1'b1;
                            entry <= 1'b0;
                        end
                    end
                    LOAD: begin
                        // an already-terminal preset skips counting entirely
                        if (pre_term) begin
                            st    <= DONE;
                            alarm <= 1'b1;
                            atmr  <= AW'(ALARM_CYCLES - 1);
                        end else begin
                            st  <= RUN;
                            run <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (cnt_term) begin
                            st    <= DONE;
                            run   <= 1'b0;
                            alarm <= 1'b1;
                            atmr  <= AW'(ALARM_CYCLES - 1);
                        end else if (k_stop) begin
                            st  <= PAUSE;
                            run <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        if (k_start) begin
                            st  <= RUN;
                            run <= 1'b1;
                        end else if (k_stop) begin
                            st    <= IDLE;
                            entry <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (k_start) begin
                            st    <= LOAD;
                            load  <= 1'b1;
                            alarm <= 1'b0;
                        end else if (k_stop) begin
                            st    <= IDLE;
                            alarm <= 1'b0;
                            entry <= 1'b1;
                        end else if (atmr == '0) begin
                            alarm <= 1'b0;
                        end else begin
                            atmr <= atmr - AW'(1);
                        end
                    end
                    default: begin
                        st    <= IDLE;
                        run   <= 1'b0;
                        alarm <= 1'b0;
                        entry <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: directed key sequences against hand-computed outputs;
// inputs change and outputs are sampled on the falling clock edge.
module tb_timer_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] key = 4'h0;
    logic       key_valid = 1'b0;
    logic       cnt_zero = 1'b0;
    logic       cnt_max = 1'b0;
    logic [3:0] pre_m, pre_c, pre_d, pre_u;
    logic       load, run, func, entry, alarm;
    logic [2:0] state;
    int         n_chk = 0;
    int         n_pass = 0;

    timer_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .key      (key),
        .key_valid(key_valid),
        .cnt_zero (cnt_zero),
        .cnt_max  (cnt_max),
        .pre_m    (pre_m),
        .pre_c    (pre_c),
        .pre_d    (pre_d),
        .pre_u    (pre_u),
        .load     (load),
        .run      (run),
        .func     (func),
        .entry    (entry),
        .alarm    (alarm),
        .state    (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic key_down(input logic [3:0] code);
        key = code;
        key_valid = 1'b1;
        cyc(1);
    endtask

    task automatic key_up();
        key_valid = 1'b0;
        cyc(1);
    endtask

    task automatic press(input logic [3:0] code);
        key_down(code);
        key_up();
    endtask

    function automatic logic [15:0] pre();
        return {pre_m, pre_c, pre_d, pre_u};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc(2);
        check("rst_state", 16'(state), 16'd0);
        check("rst_entry", 16'(entry), 16'd1);
        check("rst_outs", {12'd0, load, run, func, alarm}, 16'h0);
        check("rst_pre", pre(), 16'h0000);
        reset = 1'b1;
        cyc(1);

        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        key_down(4'd5);
        cyc(9);
        key_up();
        check("shift5_pre", pre(), 16'h2345);
        check("shift5_state", 16'(state), 16'd1);
        check("shift5_entry", 16'(entry), 16'd1);
        press(4'hE);
        press(4'hF);
        check("ignore_ef", pre(), 16'h2345);

        key_down(4'hC);
        check("clr_load", 16'(load), 16'd1);
        check("clr_pre", pre(), 16'h0000);
        check("clr_state", 16'(state), 16'd0);
        key_up();
        check("clr_load_off", 16'(load), 16'd0);
        press(4'd3);
        press(4'hD);
        check("dir_func", 16'(func), 16'd1);
        key_down(4'hA);
        check("go_load", {12'd0, 1'b0, state}, 16'd2);
        check("go_load_pulse", 16'(load), 16'd1);
        key_up();
        check("go_run_state", 16'(state), 16'd3);
        check("go_run", {14'd0, load, run}, 16'b01);
        check("go_entry", 16'(entry), 16'd0);
        press(4'd7);
        check("run_digit_ign", pre(), 16'h0003);

        key_down(4'hB);
        check("pause_state", 16'(state), 16'd4);
        check("pause_run", 16'(run), 16'd0);
        key_up();
        key_down(4'hA);
        check("resume", {12'd0, 1'b0, state}, 16'd3);
        check("resume_run_noload", {14'd0, load, run}, 16'b01);
        key_up();
        check("resume_noload2", 16'(load), 16'd0);

        cnt_zero = 1'b1;
        cyc(1);
        cnt_zero = 1'b0;
        check("term_state", 16'(state), 16'd5);
        check("term_run_alarm", {14'd0, run, alarm}, 16'b01);
        cyc(15);
        check("alarm_last", 16'(alarm), 16'd1);
        cyc(1);
        check("alarm_off", 16'(alarm), 16'd0);
        check("done_hold", 16'(state), 16'd5);

        key_down(4'hA);
        check("rerun_load", {12'd0, load, state}, 16'b1010);
        key_up();
        check("rerun_run", 16'(run), 16'd1);
        press(4'hB);
        press(4'hB);
        check("stop2_state", 16'(state), 16'd0);
        check("stop2_pre", pre(), 16'h0003);
        check("stop2_entry", 16'(entry), 16'd1);

        press(4'hC);
        check("clr_keeps_func", 16'(func), 16'd1);
        press(4'hD);
        press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        check("pre_9999", pre(), 16'h9999);
        key_down(4'hA);
        check("full_load", 16'(load), 16'd1);
        key_up();
        check("full_done", 16'(state), 16'd5);
        check("full_run_alarm", {14'd0, run, alarm}, 16'b01);
        cyc(1);
        check("full_no_run", 16'(run), 16'd0);
        key_down(4'hB);
        check("done_stop", {12'd0, alarm, state}, 16'd0);
        check("done_stop_entry", 16'(entry), 16'd1);
        key_up();

        press(4'hC);
        press(4'hA);
        check("race_run", 16'(run), 16'd1);
        cnt_max = 1'b1;
        key_down(4'hB);
        cnt_max = 1'b0;
        check("race_state", 16'(state), 16'd5);
        check("race_alarm_run", {14'd0, run, alarm}, 16'b01);
        key_up();
        press(4'hB);

        press(4'd4);
        press(4'hA);
        check("arst_pre_run", 16'(run), 16'd1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("arst_run", 16'(run), 16'd0);
        check("arst_pre", pre(), 16'h0000);
        check("arst_state", {12'd0, entry, state}, 16'b1000);
        @(negedge clock);
        reset = 1'b1;
        cyc(1);

        press(4'd5);
        press(4'hA);
        check("mclr_pre_run", 16'(state), 16'd3);
        key_down(4'hC);
        check("mclr_state", 16'(state), 16'd0);
        check("mclr_load_run", {14'd0, load, run}, 16'b10);
        check("mclr_pre", pre(), 16'h0000);
        key_up();
        check("mclr_load_off", 16'(load), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
